// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port RAM arbiter.
// Owner encoding, default sizes and the burst-counter width helper.
package mem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_MAXBURST = 4;

    // Burst counter must hold MAXBURST and is never narrower than 3 bits.
    function automatic int unsigned cnt_width(input int unsigned maxburst);
        int unsigned w;
        w = $clog2(maxburst + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Next-owner policy for mem_arb.
// MEM_ARB_RR_EN selects round-robin; otherwise EXT priority with a burst limit.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAXBURST = DEF_MAXBURST,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             owner_i,
    input  logic             cpu_pend_i,
    input  logic             ext_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic             rr_ext_next_i,
`else
    input  logic [CNT_W-1:0] burst_cnt_i,
`endif
    output logic             next_owner_o
);

`ifdef MEM_ARB_RR_EN
    // Contention goes to whoever the pointer names; a lone requester always wins.
    always_comb begin
        next_owner_o = OWN_CPU;
        if (ext_req_i && cpu_pend_i) begin
            next_owner_o = rr_ext_next_i ? OWN_EXT : OWN_CPU;
        end else if (ext_req_i) begin
            next_owner_o = OWN_EXT;
        end
    end
`else
    // burst_cnt_i already includes the current EXT cycle.
    always_comb begin
        next_owner_o = OWN_CPU;
        if (ext_req_i) begin
            next_owner_o = OWN_EXT;
            if ((owner_i == OWN_EXT) && cpu_pend_i &&
                (burst_cnt_i >= CNT_W'(MAXBURST))) begin
                next_owner_o = OWN_CPU;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-master arbiter (CPU / external loader) in front of a single-port async-read RAM.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of EXT priority with burst limit.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAXBURST = DEF_MAXBURST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_memread,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    output logic [WIDTH-1:0] cpu_memdata,
    output logic             cpu_hold,
    input  logic             ext_req,
    input  logic             ext_we,
    input  logic [WIDTH-1:0] ext_adr,
    input  logic [WIDTH-1:0] ext_wdata,
    output logic [WIDTH-1:0] ext_rdata,
    output logic             ext_ack,
    output logic             ram_memwrite,
    output logic [WIDTH-1:0] ram_adr,
    output logic [WIDTH-1:0] ram_writedata,
    input  logic [WIDTH-1:0] ram_memdata
);

    owner_e owner_q, owner_d;
    logic   cpu_pend;
    logic   next_owner;

    assign cpu_pend = cpu_memread | cpu_memwrite;

`ifdef MEM_ARB_RR_EN
    logic rr_ext_next_q, rr_ext_next_d;

    // Pointer flips away from whichever side is served this cycle.
    always_comb begin
        rr_ext_next_d = rr_ext_next_q;
        if ((owner_q == OWN_EXT) && ext_req) begin
            rr_ext_next_d = 1'b0;
        end else if ((owner_q == OWN_CPU) && cpu_pend) begin
            rr_ext_next_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ext_next_q <= 1'b1;
        end else begin
            rr_ext_next_q <= rr_ext_next_d;
        end
    end
`else
    localparam int unsigned CNT_W = cnt_width(MAXBURST);

    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    // Consecutive EXT cycles including the current one, saturating at MAXBURST.
    always_comb begin
        burst_cnt_d = '0;
        if (owner_q == OWN_EXT) begin
            burst_cnt_d = (burst_cnt_q >= CNT_W'(MAXBURST)) ? burst_cnt_q
                                                            : burst_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

    mem_arb_pick #(
`ifndef MEM_ARB_RR_EN
        .CNT_W        (CNT_W),
`endif
        .MAXBURST     (MAXBURST)
    ) u_pick (
        .owner_i      (owner_q),
        .cpu_pend_i   (cpu_pend),
        .ext_req_i    (ext_req),
`ifdef MEM_ARB_RR_EN
        .rr_ext_next_i(rr_ext_next_q),
`else
        .burst_cnt_i  (burst_cnt_d),
`endif
        .next_owner_o (next_owner)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q <= OWN_CPU;
        end else begin
            owner_q <= owner_d;
        end
    end

    // RAM-side mux on the owner; reset kills every strobe so an in-flight EXT access aborts.
    always_comb begin
        owner_d       = owner_e'(next_owner);
        ram_adr       = cpu_adr;
        ram_writedata = cpu_writedata;
        ram_memwrite  = cpu_memwrite;
        cpu_hold      = 1'b0;
        ext_ack       = 1'b0;
        if (owner_q == OWN_EXT) begin
            ram_adr       = ext_adr;
            ram_writedata = ext_wdata;
            ram_memwrite  = ext_we & ext_req;
            ext_ack       = ext_req;
            cpu_hold      = 1'b1;
        end
        if (!reset) begin
            ram_memwrite = 1'b0;
            ext_ack      = 1'b0;
            cpu_hold     = 1'b0;
        end
    end

    assign cpu_memdata = ram_memdata;
    assign ext_rdata   = ram_memdata;

endmodule
